// File: rtl/mips_debug_shell.sv
// Run-control shell around the multi-cycle MIPS core: halt/run/step/jump at instruction boundaries,
// register snapshot, cycle/instruction counters; PC breakpoint built in when DBG_BREAKPOINT_EN is defined.
module mips_debug_shell #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int CNT_W  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         core_inst_done,
    input  logic [DATA_W-1:0]            core_pc,
    input  logic [(NREGS-1)*DATA_W-1:0]  core_regs,
    output logic                         core_run,
    output logic                         core_jen,
    output logic [DATA_W-1:0]            core_jin,
    input  logic                         host_cmd_valid,
    output logic                         host_cmd_ready,
    input  logic [2:0]                   host_cmd_op,
    input  logic [DATA_W-1:0]            host_cmd_arg,
    input  logic [$clog2(NREGS)-1:0]     host_rd_sel,
    output logic [DATA_W-1:0]            host_rd_data,
    output logic [CNT_W-1:0]             cycle_cnt,
    output logic [CNT_W-1:0]             inst_cnt,
    output logic                         halted,
    output logic                         bp_hit,
    output logic                         cmd_err
);

    localparam logic [2:0] OP_HALT    = 3'd1;
    localparam logic [2:0] OP_RUN     = 3'd2;
    localparam logic [2:0] OP_STEP    = 3'd3;
    localparam logic [2:0] OP_JUMP    = 3'd4;
    localparam logic [2:0] OP_SET_BP  = 3'd5;
    localparam logic [2:0] OP_CLR_BP  = 3'd6;
    localparam logic [2:0] OP_CLR_CNT = 3'd7;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    typedef enum logic [2:0] {S_HALT, S_RUN, S_DRAIN, S_STEP, S_JUMP} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_core_run;
    logic                r_core_jen;
    logic [DATA_W-1:0]   r_core_jin;
    logic [DATA_W-1:0]   r_rd_data;
    logic [CNT_W-1:0]    r_cycle_cnt;
    logic [CNT_W-1:0]    r_inst_cnt;
    logic                r_cmd_err;
    logic [DATA_W-1:0]   r_snap [1:NREGS-1];
    logic                w_accept;
    logic                w_bp_match;
    logic                w_run_nxt;
    logic                w_jen_nxt;

    assign host_cmd_ready = (r_state == S_HALT) || (r_state == S_RUN);
    assign halted         = (r_state == S_HALT);
    assign w_accept       = host_cmd_valid && host_cmd_ready;
    assign core_run       = r_core_run;
    assign core_jen       = r_core_jen;
    assign core_jin       = r_core_jin;
    assign host_rd_data   = r_rd_data;
    assign cycle_cnt      = r_cycle_cnt;
    assign inst_cnt       = r_inst_cnt;
    assign cmd_err        = r_cmd_err;

`ifdef DBG_BREAKPOINT_EN
    logic              r_bp_valid;
    logic [DATA_W-1:0] r_bp_addr;
    logic              r_bp_hit;

    // Only a free-running core stops on the breakpoint; STEP and DRAIN finish their instruction.
    assign w_bp_match = (r_state == S_RUN) && core_inst_done && r_bp_valid && (core_pc == r_bp_addr);
    assign bp_hit     = r_bp_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bp_valid <= 1'b0;
            r_bp_addr  <= '0;
            r_bp_hit   <= 1'b0;
        end else begin
            if (w_accept && host_cmd_op == OP_SET_BP) begin
                r_bp_addr  <= host_cmd_arg;
                r_bp_valid <= 1'b1;
            end else if (w_accept && host_cmd_op == OP_CLR_BP) begin
                r_bp_valid <= 1'b0;
            end
            if (w_bp_match)
                r_bp_hit <= 1'b1;
            else if (w_accept && (host_cmd_op == OP_RUN ||
                                  (host_cmd_op == OP_STEP && r_state == S_HALT)))
                r_bp_hit <= 1'b0;
        end
    end
`else
    logic w_unused_pc;
    assign w_unused_pc = ^core_pc;
    assign w_bp_match  = 1'b0;
    assign bp_hit      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_HALT;
            r_core_run <= 1'b0;
            r_core_jen <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_core_run <= w_run_nxt;
            r_core_jen <= w_jen_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_HALT: begin
                if (w_accept) begin
                    case (host_cmd_op)
                        OP_RUN:  w_state_nxt = S_RUN;
                        OP_STEP: w_state_nxt = S_STEP;
                        OP_JUMP: w_state_nxt = S_JUMP;
                        default: w_state_nxt = S_HALT;
                    endcase
                end
            end
            S_RUN: begin
                // A HALT that coincides with a retire needs no drain.
                if (w_accept && host_cmd_op == OP_HALT)
                    w_state_nxt = core_inst_done ? S_HALT : S_DRAIN;
                else if (w_bp_match)
                    w_state_nxt = S_HALT;
            end
            S_DRAIN, S_STEP: begin
                if (core_inst_done)
                    w_state_nxt = S_HALT;
            end
            S_JUMP:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_HALT;
        endcase
    end

    always_comb begin
        w_run_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN) || (w_state_nxt == S_STEP);
        w_jen_nxt = (w_state_nxt == S_JUMP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_core_jin  <= '0;
            r_cmd_err   <= 1'b0;
            r_cycle_cnt <= '0;
            r_inst_cnt  <= '0;
        end else begin
            if (w_jen_nxt)
                r_core_jin <= host_cmd_arg;
            if (w_accept && r_state == S_RUN &&
                (host_cmd_op == OP_STEP || host_cmd_op == OP_JUMP))
                r_cmd_err <= 1'b1;
            if (w_accept && host_cmd_op == OP_CLR_CNT) begin
                r_cycle_cnt <= '0;
                r_inst_cnt  <= '0;
            end else begin
                if (r_core_run && r_cycle_cnt != '1)
                    r_cycle_cnt <= r_cycle_cnt + CNT_ONE;
                if (r_core_run && core_inst_done && r_inst_cnt != '1)
                    r_inst_cnt <= r_inst_cnt + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NREGS; i++)
                r_snap[i] <= '0;
            r_rd_data <= '0;
        end else begin
            if (core_inst_done)
                for (int i = 1; i < NREGS; i++)
                    r_snap[i] <= core_regs[(i-1)*DATA_W +: DATA_W];
            if (host_rd_sel == '0 || int'(host_rd_sel) >= NREGS)
                r_rd_data <= '0;
            else
                r_rd_data <= r_snap[host_rd_sel];
        end
    end

endmodule

// File: tb/tb_mips_debug_shell.sv
// Bench for mips_debug_shell: directed vector table, multi-cycle corner sequences, then random traffic against a reference model.
module tb_mips_debug_shell;

    localparam int DW   = 32;
    localparam int NR   = 32;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam logic [31:0] JT = 32'h0040_0020;
    localparam logic [31:0] RV = 32'h0000_1234;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  core_inst_done;
    logic [DW-1:0]         core_pc;
    logic [(NR-1)*DW-1:0]  core_regs;
    logic                  core_run;
    logic                  core_jen;
    logic [DW-1:0]         core_jin;
    logic                  host_cmd_valid;
    logic                  host_cmd_ready;
    logic [2:0]            host_cmd_op;
    logic [DW-1:0]         host_cmd_arg;
    logic [4:0]            host_rd_sel;
    logic [DW-1:0]         host_rd_data;
    logic [CW-1:0]         cycle_cnt;
    logic [CW-1:0]         inst_cnt;
    logic                  halted;
    logic                  bp_hit;
    logic                  cmd_err;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mips_debug_shell #(.DATA_W(DW), .NREGS(NR), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .core_inst_done(core_inst_done), .core_pc(core_pc), .core_regs(core_regs),
        .core_run(core_run), .core_jen(core_jen), .core_jin(core_jin),
        .host_cmd_valid(host_cmd_valid), .host_cmd_ready(host_cmd_ready),
        .host_cmd_op(host_cmd_op), .host_cmd_arg(host_cmd_arg),
        .host_rd_sel(host_rd_sel), .host_rd_data(host_rd_data),
        .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt),
        .halted(halted), .bp_hit(bp_hit), .cmd_err(cmd_err)
    );

    typedef struct {
        logic        rst, v;
        logic [2:0]  op;
        logic [31:0] arg;
        logic        done;
        logic        e_run, e_halt, e_rdy, e_jen;
        logic [31:0] e_jin;
        int          e_cyc, e_inst;
        logic        e_err;
        logic [31:0] e_rd;
    } vec_t;

    vec_t tq[$];

    task automatic add(input logic r, input logic v, input logic [2:0] op, input logic [31:0] arg,
                       input logic done, input logic run, input logic hlt, input logic rdy,
                       input logic jen, input logic [31:0] jin, input int cyc, input int inst,
                       input logic err, input logic [31:0] rd);
        vec_t t;
        t.rst = r; t.v = v; t.op = op; t.arg = arg; t.done = done;
        t.e_run = run; t.e_halt = hlt; t.e_rdy = rdy; t.e_jen = jen; t.e_jin = jin;
        t.e_cyc = cyc; t.e_inst = inst; t.e_err = err; t.e_rd = rd;
        tq.push_back(t);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; core_inst_done = 1'b0; host_cmd_valid = 1'b0;
        host_cmd_op = 3'd0; host_cmd_arg = '0;
    endtask

    task automatic run_random(input int ncyc);
        logic        m_run, m_stop, m_jump, m_err, m_bphit, m_bpv, acc, bp;
        logic [31:0] m_bpa, m_jin, m_rd;
        logic [31:0] m_snap [NR];
        int          m_cyc, m_inst;
        for (int c = 0; c < ncyc; c++) begin
            rst            = (c < 2) || ($urandom_range(0, 99) < 2);
            core_inst_done = ($urandom_range(0, 3) == 0);
            core_pc        = 32'h0040_0000 + 32'(4 * $urandom_range(0, 3));
            host_cmd_valid = ($urandom_range(0, 2) == 0);
            host_cmd_op    = 3'($urandom_range(0, 7));
            host_cmd_arg   = ($urandom_range(0, 3) == 0) ? $urandom()
                                                         : 32'h0040_0000 + 32'(4 * $urandom_range(0, 3));
            host_rd_sel    = 5'($urandom_range(0, NR - 1));
            for (int i = 0; i < NR - 1; i++) core_regs[i*DW +: DW] = $urandom();

            if (rst) begin
                m_run = 0; m_stop = 0; m_jump = 0; m_err = 0; m_bphit = 0; m_bpv = 0;
                m_bpa = 0; m_jin = 0; m_rd = 0; m_cyc = 0; m_inst = 0;
                for (int i = 0; i < NR; i++) m_snap[i] = 0;
            end else begin
                acc  = host_cmd_valid && !m_jump && !m_stop;
                m_rd = (host_rd_sel == 0) ? 32'h0 : m_snap[host_rd_sel];
                if (core_inst_done)
                    for (int i = 1; i < NR; i++) m_snap[i] = core_regs[(i-1)*DW +: DW];
                if (acc && host_cmd_op == 7) begin
                    m_cyc = 0; m_inst = 0;
                end else if (m_run) begin
                    m_cyc  = (m_cyc < CMAX) ? m_cyc + 1 : CMAX;
                    if (core_inst_done) m_inst = (m_inst < CMAX) ? m_inst + 1 : CMAX;
                end
`ifdef DBG_BREAKPOINT_EN
                bp = core_inst_done && m_bpv && (core_pc == m_bpa);
`else
                bp = 1'b0;
`endif
                if (m_jump) begin
                    m_jump = 0;
                end else if (!m_run) begin
                    if (acc && host_cmd_op == 2) begin m_run = 1; m_bphit = 0; end
                    if (acc && host_cmd_op == 3) begin m_run = 1; m_stop = 1; m_bphit = 0; end
                    if (acc && host_cmd_op == 4) begin m_jump = 1; m_jin = host_cmd_arg; end
                end else if (!m_stop) begin
                    if (acc && host_cmd_op == 2) m_bphit = 0;
                    if (acc && (host_cmd_op == 3 || host_cmd_op == 4)) m_err = 1;
                    if (bp) begin
                        m_bphit = 1; m_run = 0;
                    end else if (acc && host_cmd_op == 1) begin
                        if (core_inst_done) m_run = 0;
                        else m_stop = 1;
                    end
                end else if (core_inst_done) begin
                    m_run = 0; m_stop = 0;
                end
                if (acc && host_cmd_op == 5) begin m_bpa = host_cmd_arg; m_bpv = 1; end
                if (acc && host_cmd_op == 6) m_bpv = 0;
            end
            tick();
            chk("r_run",  core_run, m_run);
            chk("r_halt", halted, !m_run && !m_jump);
            chk("r_rdy",  host_cmd_ready, !m_jump && !m_stop);
            chk("r_jen",  core_jen, m_jump);
            chk("r_jin",  core_jin, m_jin);
            chk("r_cyc",  cycle_cnt, m_cyc);
            chk("r_inst", inst_cnt, m_inst);
            chk("r_err",  cmd_err, m_err);
            chk("r_bp",   bp_hit, m_bphit);
            chk("r_rd",   host_rd_data, m_rd);
        end
    endtask

    initial begin
        idle_inputs();
        core_pc = '0;
        host_rd_sel = 5'd5;
        for (int i = 0; i < NR - 1; i++) core_regs[i*DW +: DW] = 32'(i + 1) * 32'h0101_0101;
        core_regs[4*DW +: DW] = RV;

        //  rst v op arg           done run hlt rdy jen jin cyc inst err rd
        for (int i = 0; i < 5; i++)
            add(1, 0, 0, 0,           0,   0,  1,  1,  0,  0,  0,  0,  0,  0);
        add(0, 1, 3, 0,           0,   1,  0,  0,  0,  0,  0,  0,  0,  0);
        add(0, 0, 0, 0,           0,   1,  0,  0,  0,  0,  1,  0,  0,  0);
        add(0, 0, 0, 0,           0,   1,  0,  0,  0,  0,  2,  0,  0,  0);
        add(0, 0, 0, 0,           0,   1,  0,  0,  0,  0,  3,  0,  0,  0);
        add(0, 0, 0, 0,           1,   0,  1,  1,  0,  0,  4,  1,  0,  0);
        add(0, 0, 0, 0,           0,   0,  1,  1,  0,  0,  4,  1,  0,  RV);
        add(0, 1, 2, 0,           0,   1,  0,  1,  0,  0,  4,  1,  0,  RV);
        add(0, 0, 0, 0,           0,   1,  0,  1,  0,  0,  5,  1,  0,  RV);
        add(0, 0, 0, 0,           1,   1,  0,  1,  0,  0,  6,  2,  0,  RV);
        add(0, 1, 1, 0,           0,   1,  0,  0,  0,  0,  7,  2,  0,  RV);
        add(0, 0, 0, 0,           0,   1,  0,  0,  0,  0,  8,  2,  0,  RV);
        add(0, 0, 0, 0,           1,   0,  1,  1,  0,  0,  9,  3,  0,  RV);
        add(0, 0, 0, 0,           0,   0,  1,  1,  0,  0,  9,  3,  0,  RV);
        add(0, 1, 4, JT,          0,   0,  0,  0,  1,  JT, 9,  3,  0,  RV);
        add(0, 0, 0, 0,           0,   0,  1,  1,  0,  JT, 9,  3,  0,  RV);
        add(0, 1, 2, 0,           0,   1,  0,  1,  0,  JT, 9,  3,  0,  RV);
        add(0, 1, 4, 32'hdead,    0,   1,  0,  1,  0,  JT, 10, 3,  1,  RV);
        add(0, 1, 3, 0,           0,   1,  0,  1,  0,  JT, 11, 3,  1,  RV);
        add(0, 0, 0, 0,           0,   1,  0,  1,  0,  JT, 12, 3,  1,  RV);
        add(0, 0, 0, 0,           0,   1,  0,  1,  0,  JT, 13, 3,  1,  RV);
        add(0, 1, 7, 0,           1,   1,  0,  1,  0,  JT, 0,  0,  1,  RV);
        add(0, 0, 0, 0,           0,   1,  0,  1,  0,  JT, 1,  0,  1,  RV);

        for (int k = 0; k < tq.size(); k++) begin
            rst = tq[k].rst; host_cmd_valid = tq[k].v; host_cmd_op = tq[k].op;
            host_cmd_arg = tq[k].arg; core_inst_done = tq[k].done;
            tick();
            chk($sformatf("run[%0d]", k),  core_run, tq[k].e_run);
            chk($sformatf("halt[%0d]", k), halted, tq[k].e_halt);
            chk($sformatf("rdy[%0d]", k),  host_cmd_ready, tq[k].e_rdy);
            chk($sformatf("jen[%0d]", k),  core_jen, tq[k].e_jen);
            chk($sformatf("jin[%0d]", k),  core_jin, tq[k].e_jin);
            chk($sformatf("cyc[%0d]", k),  cycle_cnt, tq[k].e_cyc);
            chk($sformatf("inst[%0d]", k), inst_cnt, tq[k].e_inst);
            chk($sformatf("err[%0d]", k),  cmd_err, tq[k].e_err);
            chk($sformatf("rd[%0d]", k),   host_rd_data, tq[k].e_rd);
            chk($sformatf("bp[%0d]", k),   bp_hit, 1'b0);
        end
        idle_inputs();

        // Counter saturation while running (state RUN, cycle_cnt=1, inst_cnt=0).
        repeat (20) tick();
        chk("cyc_sat", cycle_cnt, CMAX);
        core_inst_done = 1'b1;
        repeat (20) tick();
        chk("inst_sat", inst_cnt, CMAX);

        // HALT coinciding with a retire skips DRAIN.
        host_cmd_valid = 1'b1; host_cmd_op = 3'd1;
        tick();
        idle_inputs();
        chk("hd_run", core_run, 1'b0);
        chk("hd_halt", halted, 1'b1);
        chk("hd_rdy", host_cmd_ready, 1'b1);

        // Reset while the jump strobe is up: no further pulse.
        host_cmd_valid = 1'b1; host_cmd_op = 3'd4; host_cmd_arg = 32'h55;
        tick();
        idle_inputs();
        chk("rj_jen1", core_jen, 1'b1);
        rst = 1'b1;
        tick();
        chk("rj_jen0", core_jen, 1'b0);
        chk("rj_halt", halted, 1'b1);
        chk("rj_jin", core_jin, 32'h0);
        chk("rj_err", cmd_err, 1'b0);
        rst = 1'b0;
        tick();
        chk("rj_jen0b", core_jen, 1'b0);
        chk("rj_cyc", cycle_cnt, 0);

        // Breakpoint sequence.
        host_cmd_valid = 1'b1; host_cmd_op = 3'd5; host_cmd_arg = 32'h0040_0008;
        tick();
        host_cmd_op = 3'd2;
        tick();
        idle_inputs();
        chk("bp_run", core_run, 1'b1);
        core_pc = 32'h0040_0000; core_inst_done = 1'b1;
        tick();
        chk("bp_miss", core_run, 1'b1);
        core_pc = 32'h0040_0008;
        tick();
        core_inst_done = 1'b0;
`ifdef DBG_BREAKPOINT_EN
        chk("bp_stop", core_run, 1'b0);
        chk("bp_halt", halted, 1'b1);
        chk("bp_hit", bp_hit, 1'b1);
        host_cmd_valid = 1'b1; host_cmd_op = 3'd2;
        tick();
        idle_inputs();
        chk("bp_clr", bp_hit, 1'b0);
        chk("bp_rerun", core_run, 1'b1);
`else
        chk("nbp_run", core_run, 1'b1);
        chk("nbp_halt", halted, 1'b0);
        chk("nbp_hit", bp_hit, 1'b0);
`endif
        host_cmd_valid = 1'b1; host_cmd_op = 3'd1; core_inst_done = 1'b1;
        tick();
        idle_inputs();
        chk("end_halt", halted, 1'b1);

        run_random(3000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mips_debug_shell.md
# mips_debug_shell

Parametrised debug/run-control shell that replaces the fixed board wrapper around the multi-cycle MIPS core. It gates the core's execution at instruction boundaries and lets a host halt, run, single-step and inject a jump target. It snapshots the register file on every completed instruction, counts cycles and instructions, and, when compiled in, halts on a PC breakpoint. It sits between the core's InstDone/Jen/Jin/Jout/R1..R31 ports and a host command port.

## Interface
Parameters:
- DATA_W, 32, register and PC width
- NREGS, 32, architectural registers; register 0 always reads 0 and is not stored
- CNT_W, 32, width of cycle and instruction counters

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- core_inst_done  in  1  one-cycle pulse when the core retires an instruction
- core_pc  in  DATA_W  PC of the retiring instruction, valid with core_inst_done
- core_regs  in  (NREGS-1)*DATA_W  flattened R1..R(NREGS-1), R1 in the LSBs
- core_run  out  1  registered core enable; core fetches only when high
- core_jen  out  1  one-cycle jump-load strobe
- core_jin  out  DATA_W  jump target, valid with core_jen
- host_cmd_valid  in  1  command request
- host_cmd_ready  out  1  command accept
- host_cmd_op  in  3  0 NOP, 1 HALT, 2 RUN, 3 STEP, 4 JUMP, 5 SET_BP, 6 CLR_BP, 7 CLR_CNT
- host_cmd_arg  in  DATA_W  JUMP target / breakpoint address
- host_rd_sel  in  $clog2(NREGS)  snapshot register index
- host_rd_data  out  DATA_W  selected snapshot register
- cycle_cnt  out  CNT_W  cycles with core_run high
- inst_cnt  out  CNT_W  retired instructions
- halted  out  1  high in HALT
- bp_hit  out  1  sticky breakpoint flag, cleared by RUN/STEP
- cmd_err  out  1  sticky illegal-command flag, cleared by reset only

## Operation
- States: HALT (reset), RUN, DRAIN, STEP, JUMP.
- A command is accepted on host_cmd_valid && host_cmd_ready. host_cmd_ready is high in HALT and RUN only.
- HALT state:
  - RUN -> RUN.
  - STEP -> STEP.
  - JUMP -> JUMP.
  - HALT and NOP are accepted with no effect.
- RUN state:
  - HALT -> DRAIN.
  - STEP or JUMP is accepted, ignored, and sets cmd_err.
- DRAIN: core_run stays high until core_inst_done, then -> HALT.
- STEP: core_run high until core_inst_done, then -> HALT.
- JUMP: core_jen=1 and core_jin=latched arg for exactly one cycle, core_run=0, then -> HALT.
- Commands 5, 6 and 7 are accepted in HALT or RUN without a state change:
  - SET_BP loads bp_addr and sets bp_valid.
  - CLR_BP clears bp_valid.
  - CLR_CNT zeroes both counters.
- Snapshot: on every core_inst_done, all core_regs are latched.
- host_rd_data is registered: snapshot[host_rd_sel]; index 0 and indices >= NREGS return 0.
- Counters saturate at all-ones. CLR_CNT in the same cycle as an increment: clear wins.
- inst_cnt increments on core_inst_done while core_run=1.
- Reset values: core_run 0, core_jen 0, core_jin 0, host_rd_data 0, counters 0, snapshot 0, bp_valid 0, bp_hit 0, cmd_err 0, halted 1.
- Reset mid-operation (any state) returns to HALT next cycle, with no further core_jen pulse.

## Timing
- core_run is registered. It changes on the edge after the accepting or ending event:
  - RUN accept -> core_run=1 next cycle.
  - core_inst_done in DRAIN/STEP -> core_run=0 next cycle, so the core fetches nothing further.
- JUMP: core_jen high in the cycle after acceptance; host_cmd_ready low that cycle.
- host_rd_data latency is 1 cycle from host_rd_sel. A snapshot written in cycle N is visible on a read selected in cycle N+1.
- HALT accepted in the same cycle as core_inst_done in RUN goes straight to HALT; DRAIN is skipped.

## Configuration
- DBG_BREAKPOINT_EN defined:
  - In RUN, core_inst_done with bp_valid && core_pc==bp_addr -> HALT, with core_run=0 next cycle and bp_hit set.
  - STEP ignores the breakpoint.
- Undefined: no comparator or bp_addr storage. SET_BP and CLR_BP are accepted as NOPs, and bp_hit is tied 0.

## Test plan
- Reset, then hold 5 cycles -> halted=1, core_run=0, counters 0, host_rd_data 0, host_cmd_ready=1.
- STEP from HALT, core_inst_done after 4 cycles with R5=0x1234 -> core_run high 4 cycles then 0, inst_cnt=1, cycle_cnt=4, sel=5 reads 0x1234.
- RUN, then HALT issued mid-instruction -> DRAIN until the next core_inst_done, then halted=1 with no extra fetch cycle.
- JUMP arg=0x00400020 from HALT -> single core_jen pulse with core_jin=0x00400020, core_run stays 0. JUMP while RUN -> ignored, cmd_err=1.
- DBG_BREAKPOINT_EN: SET_BP 0x00400008, RUN, core_pc=0x00400008 at retire -> bp_hit=1, halted=1. A subsequent RUN clears bp_hit.
- CNT_W=4, RUN for 20 cycles -> cycle_cnt saturates at 15. CLR_CNT coinciding with an increment -> 0.
